dp_sequencer: RTL
=================

DP_SEQUENCER -- requirements
Module: dp_sequencer

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  run request
- n  in  4  iteration count, unsigned
- E  out  1  datapath output-enable (bus B1 -> outr)
- LD_R1, LD_R2, LD_R3  out  1 each  register loads
- LD_DR1, LD_DR2  out  1 each  operand loads
- LD_AC, LD_outr  out  1 each  accumulator and output loads
- sel_A  out  3  B1 source: 000 R1, 001 R2, 010 R3, 011 AC, 100 outr
- sel_B  out  1  B2 source select
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- iter  out  4  completed-iteration count

Function
REQ-002 The FSM SHALL have states IDLE, T0, T1, T2, T3, OUT and DONE, encoded in 3 bits and registered.
REQ-003 In IDLE, start=1 SHALL latch n into an internal count register, clear iter, and move to T0 if n!=0 or to OUT if n==0.
REQ-004 T0 SHALL drive LD_DR1=1, LD_DR2=1 and sel_A=000, giving DR1<=R1 and DR2<=R2.
REQ-005 T1 SHALL drive LD_R1=1, LD_AC=1 and sel_A=001, giving AC<=DR1+DR2 and R1<=R2.
REQ-006 T2 SHALL drive LD_R3=1 and sel_A=011, giving R3<=AC.
REQ-007 T3 SHALL drive LD_R2=1 and sel_A=010 (R2<=R3) and SHALL increment iter, modulo 16.
REQ-008 From T3 the FSM SHALL go to T0 if iter+1 < latched n, otherwise to OUT.
REQ-009 OUT SHALL drive E=1, LD_outr=1 and sel_A=010 (outr<=R3) for exactly one cycle, then go to DONE.
REQ-010 DONE SHALL drive done=1 for one cycle and then return to IDLE.
REQ-011 busy SHALL be 1 in states T0 through OUT and 0 in IDLE and DONE.
REQ-012 sel_B SHALL be constant 1.
REQ-013 In any state not listed for a signal, every LD_* and E SHALL be 0 and sel_A SHALL be 000.
REQ-014 All control outputs SHALL be decoded from the registered state only (Moore), with no combinational path from start to any output.
REQ-015 start SHALL be ignored in every state except IDLE, including DONE; the n input is not sampled outside IDLE.
REQ-016 Latency from the cycle start is sampled to the done pulse SHALL be 4*n+2 cycles for n>=1 and 2 cycles for n==0.
REQ-017 n=15 SHALL run 15 iterations, and iter SHALL hold the final count until the next accepted start.
REQ-018 The pairs (LD_DR1, LD_DR2) and (LD_R1, LD_AC) SHALL always be asserted together.

Reset
REQ-019 While rst=1 at a clock edge, the FSM SHALL go to IDLE and iter and the latched count SHALL clear to 0.
REQ-020 After reset, every LD_*, E, busy and done SHALL read 0, sel_A SHALL read 000, and sel_B SHALL read 1.
REQ-021 rst SHALL take priority over start and over any state transition, including mid-sequence, and no partial iteration SHALL continue afterwards.

Structure
REQ-022 A shared package dp_pkg SHALL hold the state typedef, the sel_A source codes (SRC_R1..SRC_OUTR) and the ITER_W=4 constant.
REQ-023 The block SHALL be a single module with no sub-module; a testbench wrapper dp_top SHALL instance dp_sequencer together with the datapath.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- n=1, start pulse: sequence T0,T1,T2,T3,OUT,DONE; done pulses 6 cycles after start is sampled; iter=1.
- n=3: exactly 3 LD_R2 pulses; done at start+14; E high exactly 1 cycle.
- n=0: IDLE->OUT->DONE; no LD_DR*/LD_R*/LD_AC pulses; done at start+2.
- start held high through a whole run with n=2: only one run; a second run begins only from IDLE after DONE.
- rst asserted during T2 of iteration 2 with n=4: next state IDLE, iter=0, no done pulse, all outputs at reset values.
- n=15 in the top-level with the datapath seeded R1=1, R2=1: done at start+62; iter=15; every cycle's LD_*/sel_A checked against REQ-004..REQ-009.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared definitions for the dp_sequencer control block and its datapath.
//   state_t      : sequencer FSM states (3-bit, registered)
//   SRC_*        : sel_A codes choosing the source driven onto bus B1
//   ITER_W       : width of the iteration count / n input
//   DATA_W       : datapath register width
package dp_pkg;

    localparam int ITER_W = 4;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        T3   = 3'd4,
        OUT  = 3'd5,
        DONE = 3'd6
    } state_t;

    localparam logic [2:0] SRC_R1   = 3'b000;
    localparam logic [2:0] SRC_R2   = 3'b001;
    localparam logic [2:0] SRC_R3   = 3'b010;
    localparam logic [2:0] SRC_AC   = 3'b011;
    localparam logic [2:0] SRC_OUTR = 3'b100;

endpackage

// File: rtl/dp_sequencer_if.sv
// Control bus between the sequencer and the datapath.
//   master : sequencer side, drives enables/loads/selects
//   slave  : datapath side, consumes them
interface dp_sequencer_if;
    logic       E;
    logic       LD_R1;
    logic       LD_R2;
    logic       LD_R3;
    logic       LD_DR1;
    logic       LD_DR2;
    logic       LD_AC;
    logic       LD_outr;
    logic [2:0] sel_A;
    logic       sel_B;

    modport master (
        output E, LD_R1, LD_R2, LD_R3, LD_DR1, LD_DR2, LD_AC, LD_outr, sel_A, sel_B
    );

    modport slave (
        input E, LD_R1, LD_R2, LD_R3, LD_DR1, LD_DR2, LD_AC, LD_outr, sel_A, sel_B
    );
endinterface

// File: rtl/dp_datapath.sv
// Register datapath driven by the sequencer control bus.
// B1 is a 5-way mux chosen by sel_A; B2 feeds DR2 (sel_B=1 -> R2, else R1).
// seed preloads R1/R2 so a run computes a Fibonacci-style sequence.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   seed, r1/r2_init   : preload of R1/R2 (wins over control loads)
//   ctrl               : control bus (slave side)
//   outr               : output register
module dp_datapath
    import dp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              seed,
    input  logic [DATA_W-1:0] r1_init,
    input  logic [DATA_W-1:0] r2_init,
    dp_sequencer_if.slave     ctrl,
    output logic [DATA_W-1:0] outr
);

    logic [DATA_W-1:0] r1, r2, r3, dr1, dr2, ac;
    logic [DATA_W-1:0] b1, b2;

    always_comb begin
        case (ctrl.sel_A)
            SRC_R1:   b1 = r1;
            SRC_R2:   b1 = r2;
            SRC_R3:   b1 = r3;
            SRC_AC:   b1 = ac;
            SRC_OUTR: b1 = outr;
            default:  b1 = '0;
        endcase
    end

    assign b2 = ctrl.sel_B ? r2 : r1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r1   <= '0;
            r2   <= '0;
            r3   <= '0;
            dr1  <= '0;
            dr2  <= '0;
            ac   <= '0;
            outr <= '0;
        end else if (seed) begin
            r1 <= r1_init;
            r2 <= r2_init;
        end else begin
            if (ctrl.LD_DR1) dr1 <= b1;
            if (ctrl.LD_DR2) dr2 <= b2;
            if (ctrl.LD_AC)  ac  <= dr1 + dr2;
            if (ctrl.LD_R1)  r1  <= b1;
            if (ctrl.LD_R2)  r2  <= b1;
            if (ctrl.LD_R3)  r3  <= b1;
            if (ctrl.LD_outr && ctrl.E) outr <= b1;
        end
    end

endmodule

// File: rtl/dp_top.sv
// Wrapper pairing dp_sequencer with dp_datapath over a shared control bus.
// The bus is an interface port so the surrounding environment can observe it.
// Ports:
//   clk, rst, start, n : as dp_sequencer
//   seed, r1/r2_init   : datapath preload
//   busy, done, iter   : sequencer status
//   outr               : datapath result
//   bus                : control bus instance
module dp_top
    import dp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ITER_W-1:0] n,
    input  logic              seed,
    input  logic [DATA_W-1:0] r1_init,
    input  logic [DATA_W-1:0] r2_init,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter,
    output logic [DATA_W-1:0] outr,
    dp_sequencer_if           bus
);

    dp_sequencer u_seq (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .n       (n),
        .E       (bus.E),
        .LD_R1   (bus.LD_R1),
        .LD_R2   (bus.LD_R2),
        .LD_R3   (bus.LD_R3),
        .LD_DR1  (bus.LD_DR1),
        .LD_DR2  (bus.LD_DR2),
        .LD_AC   (bus.LD_AC),
        .LD_outr (bus.LD_outr),
        .sel_A   (bus.sel_A),
        .sel_B   (bus.sel_B),
        .busy    (busy),
        .done    (done),
        .iter    (iter)
    );

    dp_datapath u_dp (
        .clk     (clk),
        .rst     (rst),
        .seed    (seed),
        .r1_init (r1_init),
        .r2_init (r2_init),
        .ctrl    (bus),
        .outr    (outr)
    );

endmodule

// File: rtl/dp_sequencer.sv
// Moore control sequencer for an iterative add/shift datapath.
// Each iteration walks T0..T3 (load operands, add + shift R1, move AC to
// R3, move R3 to R2); after n iterations OUT copies R3 to outr and DONE
// pulses for one cycle.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, n          : run request and iteration count (sampled in IDLE only)
//   E, LD_*           : datapath output-enable and register loads
//   sel_A, sel_B      : bus B1 / B2 source selects
//   busy, done, iter  : status, completion pulse, completed-iteration count
module dp_sequencer
    import dp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ITER_W-1:0] n,
    output logic              E,
    output logic              LD_R1,
    output logic              LD_R2,
    output logic              LD_R3,
    output logic              LD_DR1,
    output logic              LD_DR2,
    output logic              LD_AC,
    output logic              LD_outr,
    output logic [2:0]        sel_A,
    output logic              sel_B,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter
);

    state_t            state, state_nxt;
    logic [ITER_W-1:0] cnt;
    logic              last_iter;

    // One bit wider so iter+1 cannot wrap before the compare (n = 15 case).
    assign last_iter = ({1'b0, iter} + (ITER_W+1)'(1)) >= {1'b0, cnt};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            iter  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                cnt  <= n;
                iter <= '0;
            end else if (state == T3) begin
                iter <= iter + ITER_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        E         = 1'b0;
        LD_R1     = 1'b0;
        LD_R2     = 1'b0;
        LD_R3     = 1'b0;
        LD_DR1    = 1'b0;
        LD_DR2    = 1'b0;
        LD_AC     = 1'b0;
        LD_outr   = 1'b0;
        sel_A     = SRC_R1;
        sel_B     = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (n != '0) ? T0 : OUT;
            end
            T0: begin
                LD_DR1    = 1'b1;
                LD_DR2    = 1'b1;
                sel_A     = SRC_R1;
                busy      = 1'b1;
                state_nxt = T1;
            end
            T1: begin
                LD_R1     = 1'b1;
                LD_AC     = 1'b1;
                sel_A     = SRC_R2;
                busy      = 1'b1;
                state_nxt = T2;
            end
            T2: begin
                LD_R3     = 1'b1;
                sel_A     = SRC_AC;
                busy      = 1'b1;
                state_nxt = T3;
            end
            T3: begin
                LD_R2     = 1'b1;
                sel_A     = SRC_R3;
                busy      = 1'b1;
                state_nxt = last_iter ? OUT : T0;
            end
            OUT: begin
                E         = 1'b1;
                LD_outr   = 1'b1;
                sel_A     = SRC_R3;
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
